// File: rtl/cluster_pwr_pkg.sv
// Shared types and constants for the cluster power/clock/reset sequencer.
package cluster_pwr_pkg;

    localparam int unsigned STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        OFF     = 4'd0,
        PWR_UP  = 4'd1,
        CLK_ON  = 4'd2,
        ISO_REL = 4'd3,
        RUN     = 4'd4,
        DRAIN   = 4'd5,
        ISO_ON  = 4'd6,
        RST_ON  = 4'd7,
        CLK_OFF = 4'd8
    } state_e;

    localparam int unsigned DEF_PWR_UP_CYCLES = 16;
    localparam int unsigned DEF_RST_CYCLES    = 8;
    localparam int unsigned DEF_ISO_CYCLES    = 2;
    localparam int unsigned DEF_DRAIN_TIMEOUT = 1024;
    localparam int unsigned DEF_CNT_WIDTH     = 16;

    function automatic int unsigned max_u(int unsigned a, int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // True when a counter of 'width' bits can hold max_cycles-1.
    function automatic bit cnt_width_ok(int unsigned width, int unsigned max_cycles);
        if (width >= 32) return 1'b1;
        return (max_cycles - 1) < (32'd1 << width);
    endfunction

endpackage

// File: rtl/cluster_pwr_timer.sv
// Loadable down-counter, saturating at zero; shared by dwell and drain timeout.
module cluster_pwr_timer #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             zero_c
);

    logic [WIDTH-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - WIDTH'(1);
        end
    end

    assign zero_c = (cnt == '0);

endmodule

// File: rtl/cluster_pwr_seq.sv
// Cluster power sequencer: orders clock gate, reset, isolation and fetch enable
// on power-up, and drains then reverses the sequence on power-down.
module cluster_pwr_seq
    import cluster_pwr_pkg::*;
#(
    parameter int unsigned PWR_UP_CYCLES = DEF_PWR_UP_CYCLES,
    parameter int unsigned RST_CYCLES    = DEF_RST_CYCLES,
    parameter int unsigned ISO_CYCLES    = DEF_ISO_CYCLES,
    parameter int unsigned DRAIN_TIMEOUT = DEF_DRAIN_TIMEOUT,
    parameter int unsigned CNT_WIDTH     = DEF_CNT_WIDTH
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        pow_req_i,
    input  logic        byp_i,
    input  logic        fetch_en_i,
    input  logic [63:0] boot_addr_i,
    input  logic        cluster_busy_i,
    output logic        cluster_clk_en_o,
    output logic        cluster_rstn_o,
    output logic        cluster_iso_o,
    output logic        cluster_fetch_en_o,
    output logic [63:0] cluster_boot_addr_o,
    output logic        pow_ack_o,
    output logic        drain_err_o,
    output logic [3:0]  state_o
);

    localparam int unsigned MAX_CYC = max_u(max_u(PWR_UP_CYCLES, RST_CYCLES),
                                            max_u(ISO_CYCLES, DRAIN_TIMEOUT));

    if (!cnt_width_ok(CNT_WIDTH, MAX_CYC)) begin : g_cnt_width_check
        $error("cluster_pwr_seq: CNT_WIDTH cannot hold the largest dwell/timeout");
    end

    localparam logic [CNT_WIDTH-1:0] PWR_UP_LD = CNT_WIDTH'(PWR_UP_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] RST_LD    = CNT_WIDTH'(RST_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] ISO_LD    = CNT_WIDTH'(ISO_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] DRAIN_LD  = CNT_WIDTH'(DRAIN_TIMEOUT - 1);

    state_e               state;
    state_e               next;
    logic                 tmr_load;
    logic [CNT_WIDTH-1:0] tmr_load_val;
    logic                 tmr_dec;
    logic                 tmr_zero;
    logic                 drain_to;
    logic                 nxt_clk_en;
    logic                 nxt_rstn;
    logic                 nxt_iso;
    logic                 nxt_run;
    logic                 nxt_fetch;

    cluster_pwr_timer #(
        .WIDTH (CNT_WIDTH)
    ) u_timer (
        .clk      (clk_i),
        .rst      (rst_i),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .dec      (tmr_dec),
        .zero_c   (tmr_zero)
    );

    // State and output registers; outputs follow the state being entered.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state               <= OFF;
            cluster_clk_en_o    <= 1'b0;
            cluster_rstn_o      <= 1'b0;
            cluster_iso_o       <= 1'b1;
            cluster_fetch_en_o  <= 1'b0;
            cluster_boot_addr_o <= '0;
            pow_ack_o           <= 1'b0;
            drain_err_o         <= 1'b0;
        end else begin
            state              <= next;
            cluster_clk_en_o   <= nxt_clk_en;
            cluster_rstn_o     <= nxt_rstn;
            cluster_iso_o      <= nxt_iso;
            cluster_fetch_en_o <= nxt_fetch;
            if (nxt_fetch && !cluster_fetch_en_o) begin
                cluster_boot_addr_o <= boot_addr_i;
            end
            pow_ack_o   <= nxt_run;
            drain_err_o <= drain_err_o | drain_to;
        end
    end

    // Next state and timer control. Aborts during power-up skip the drain.
    always_comb begin
        next         = state;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        tmr_dec      = 1'b0;
        drain_to     = 1'b0;
        case (state)
            OFF: begin
                if (pow_req_i) begin
                    next         = PWR_UP;
                    tmr_load     = 1'b1;
                    tmr_load_val = byp_i ? '0 : PWR_UP_LD;
                end
            end
            PWR_UP: begin
                tmr_dec = 1'b1;
                if (!pow_req_i) begin
                    next = CLK_OFF;
                end else if (tmr_zero) begin
                    next         = CLK_ON;
                    tmr_load     = 1'b1;
                    tmr_load_val = RST_LD;
                end
            end
            CLK_ON: begin
                tmr_dec = 1'b1;
                if (!pow_req_i) begin
                    next = CLK_OFF;
                end else if (tmr_zero) begin
                    next         = ISO_REL;
                    tmr_load     = 1'b1;
                    tmr_load_val = ISO_LD;
                end
            end
            ISO_REL: begin
                tmr_dec = 1'b1;
                if (!pow_req_i) begin
                    next = CLK_OFF;
                end else if (tmr_zero) begin
                    next = RUN;
                end
            end
            RUN: begin
                if (!pow_req_i) begin
                    next         = DRAIN;
                    tmr_load     = 1'b1;
                    tmr_load_val = DRAIN_LD;
                end
            end
            DRAIN: begin
                tmr_dec = 1'b1;
                // Busy low wins over an expiring timeout in the same cycle.
                if (!cluster_busy_i || tmr_zero) begin
                    next         = ISO_ON;
                    tmr_load     = 1'b1;
                    tmr_load_val = ISO_LD;
                    drain_to     = cluster_busy_i;
                end
            end
            ISO_ON: begin
                tmr_dec = 1'b1;
                if (tmr_zero) begin
                    next = RST_ON;
                end
            end
            RST_ON:  next = CLK_OFF;
            CLK_OFF: next = OFF;
            default: next = CLK_OFF;
        endcase
    end

    // Output levels decoded from the state being entered.
    always_comb begin
        nxt_clk_en = 1'b0;
        nxt_rstn   = 1'b0;
        nxt_iso    = 1'b1;
        case (next)
            CLK_ON, RST_ON: begin
                nxt_clk_en = 1'b1;
            end
            ISO_REL, ISO_ON: begin
                nxt_clk_en = 1'b1;
                nxt_rstn   = 1'b1;
            end
            RUN, DRAIN: begin
                nxt_clk_en = 1'b1;
                nxt_rstn   = 1'b1;
                nxt_iso    = 1'b0;
            end
            default: ;
        endcase
        nxt_run   = (next == RUN);
        nxt_fetch = fetch_en_i && nxt_run;
    end

    assign state_o = state;

endmodule
